// File: rtl/pcie_ser_pkg.sv
// Shared types and constants for the PCIe lane serializer.
// Build option: define PCIE_SER_IDLE_FILL_EN to fill symbol gaps with IDLE_SYM.
package pcie_ser_pkg;

  // Shifter state: empty, or holding a symbol being shifted out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  localparam int SYM_W_DEF = 10;

  // K28.5 comma symbol, the default gap filler.
  localparam logic [9:0] K28_5 = 10'h0FA;

endpackage

// File: rtl/pcie_ser_holdbuf.sv
// One-entry holding register between the encoder and the shifter.
//
// Handshake: a symbol transfers on a clock edge where sym_valid && sym_ready.
// sym_ready is high when the buffer is empty, or when the shifter drains it
// on this same edge (load_now), so a drain and a refill can share one edge.
// Transfers do not depend on the shift enable.
module pcie_ser_holdbuf #(
  parameter int SYM_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  input  logic             load_now,
  output logic             sym_ready,
  output logic             hold_full,
  output logic [SYM_W-1:0] hold
);

  logic transfer;

  assign sym_ready = !hold_full || load_now;
  assign transfer  = sym_valid && sym_ready;

  // Capture on transfer; a drain without a refill empties the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else if (transfer) begin
      hold_full <= 1'b1;
      hold      <= sym_in;
    end else if (load_now) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/pcie_ser_piso.sv
// Parallel-in/serial-out symbol serializer, LSB first, one bit per enabled
// clock, back-to-back symbols with no bubble.
// Build option: PCIE_SER_IDLE_FILL_EN -- once a data symbol has been shifted,
// gaps are filled with IDLE_SYM instead of returning to idle.
module pcie_ser_piso
  import pcie_ser_pkg::*;
#(
  parameter int             SYM_W    = SYM_W_DEF,
  parameter logic [SYM_W-1:0] IDLE_SYM = SYM_W'(K28_5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sym_start,
  output logic             dbg_state
);

  localparam int CW = (SYM_W > 1) ? $clog2(SYM_W) : 1;

  ser_state_e       state;
  logic [CW-1:0]    bcnt;
  logic [SYM_W-1:0] shifter;
  logic [SYM_W-1:0] hold;
  logic             hold_full;
  logic             last_bit;
  logic             load_now;

  assign last_bit = (state == ST_SHIFT) && (bcnt == CW'(SYM_W - 1));
  assign load_now = en && hold_full && ((state == ST_IDLE) || last_bit);

  pcie_ser_holdbuf #(
    .SYM_W (SYM_W)
  ) u_holdbuf (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .load_now  (load_now),
    .sym_ready (sym_ready),
    .hold_full (hold_full),
    .hold      (hold)
  );

`ifndef PCIE_SER_IDLE_FILL_EN
  // Filler symbol only matters in the fill build.
  logic unused_idle_sym;
  assign unused_idle_sym = ^IDLE_SYM;
`endif

  // Shifter FSM: load from the holding buffer, shift while enabled, and at
  // the last bit either reload, fill, or fall back to idle. The shifter is
  // cleared on idle so sout reads 0 there. With en low everything freezes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bcnt    <= '0;
      shifter <= '0;
    end else if (en) begin
      if (load_now) begin
        state   <= ST_SHIFT;
        bcnt    <= '0;
        shifter <= hold;
      end else if (state == ST_SHIFT) begin
        if (last_bit) begin
`ifdef PCIE_SER_IDLE_FILL_EN
          // SHIFT is only ever entered through a data load, so being here
          // means a data symbol has already gone out since reset.
          bcnt    <= '0;
          shifter <= IDLE_SYM;
`else
          state   <= ST_IDLE;
          bcnt    <= '0;
          shifter <= '0;
`endif
        end else begin
          bcnt    <= bcnt + CW'(1);
          shifter <= shifter >> 1;
        end
      end
    end
  end

  assign sout       = shifter[0];
  assign sout_valid = (state == ST_SHIFT);
  assign sym_start  = (state == ST_SHIFT) && (bcnt == '0);
  assign dbg_state  = state;

endmodule

// File: doc/pcie_ser_piso.md
# pcie_ser_piso

Parametrised parallel-in/serial-out symbol serializer for the PCIe transmit lane, placed after the 8b/10b encoder. Accepts one SYM_W-bit symbol per valid/ready handshake into a one-entry holding buffer and shifts it out LSB-first, one bit per enabled clock, with no bubble between back-to-back symbols. Provides a bit-valid qualifier and a symbol-start marker to the lane driver. Optionally fills gaps with an idle symbol.

## Interface

- SYM_W, 10, symbol width in bits (≥2)
- IDLE_SYM, 10'h0FA, idle/fill symbol (SYM_W bits), used only with fill enabled

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  shift enable; low = stall (all state frozen)
- sym_in  in  SYM_W  parallel symbol
- sym_valid  in  1  sym_in valid
- sym_ready  out  1  holding buffer can accept
- sout  out  1  serial bit (registered)
- sout_valid  out  1  sout carries a symbol bit
- sym_start  out  1  high while bit 0 of a symbol is on sout

## Operation

- States: IDLE (shifter empty), SHIFT (shifter holds symbol, bit counter bcnt 0..SYM_W-1).
- Handshake: transfer when sym_valid && sym_ready at a clock edge; transfer is independent of en.
- sym_ready = !hold_full || load_now; load_now = en && hold_full && (IDLE || (SHIFT && bcnt==SYM_W-1)).
- On load_now: shifter <= hold, bcnt <= 0, hold_full cleared unless a new transfer occurs the same edge (simultaneous drain and fill keeps hold_full=1 with the new symbol).
- SHIFT with en: shifter >> 1, bcnt+1; at bcnt==SYM_W-1 without load_now -> IDLE (or fill, see Configuration).
- sout = shifter[0]; sout_valid=1 in SHIFT, 0 in IDLE; sym_start = SHIFT && bcnt==0.
- In IDLE sout=0.
- sym_in is ignored when sym_valid is low; sym_valid dropping while ready low is legal (no transfer).

## Timing

- Reset (rst low, any time): sout=0, sout_valid=0, sym_start=0, hold_full=0 (sym_ready=1), state IDLE, bcnt=0; partial symbol discarded.
- Latency: transfer at edge k (shifter IDLE, en=1) -> hold at k; load at k+1; bit0 on sout from edge k+1 to k+2, bit i from edge k+1+i.
- Sustained throughput: one symbol per SYM_W enabled cycles; next symbol's bit 0 directly follows previous bit SYM_W-1.
- en low: sout, sout_valid, bcnt, shifter, state hold; a transfer may still fill an empty hold buffer.
- Full hold + SHIFT not at last bit: sym_ready=0.

## Configuration

- PCIE_SER_IDLE_FILL_EN defined: once the first data symbol since reset has been loaded, SHIFT at bcnt==SYM_W-1 with hold empty loads IDLE_SYM instead of going IDLE; sout_valid stays 1, sym_start pulses for the fill symbol. A data symbol arriving mid-fill waits until the fill symbol completes. Before the first data symbol, block stays IDLE.
- Not defined: gaps return to IDLE, sout=0, sout_valid=0; IDLE_SYM unused.

## Structure

- Package pcie_ser_pkg: state enum (ST_IDLE, ST_SHIFT), default SYM_W, K28.5 constant 10'h0FA used as IDLE_SYM default.
- Sub-module pcie_ser_holdbuf: one-entry SYM_W holding register with valid/ready in, load_now drain; shifter, counter and FSM in the top.

## Test plan

- Reset then sym_in=10'h2AA, one transfer, en=1 -> sout 0,1,0,1,… starting one edge after transfer; sym_start one cycle; sout_valid for exactly 10 cycles, then 0.
- Back-to-back 10'h3FF then 10'h000, sym_valid held high -> 10 ones then 10 zeros, no gap; sym_ready low except at drain cycles.
- en toggled 1/0 every cycle during 10'h155 -> each bit held two cycles, correct order, sout_valid for 20 cycles.
- rst asserted at bit 4 of 10'h3C3 with hold full -> next cycle sout=0, sout_valid=0, sym_ready=1; after release no stale symbol emitted.
- Transfer while shifter at bcnt==9 and hold full -> hold drains and refills same edge, both symbols output in order.
- With PCIE_SER_IDLE_FILL_EN: one data symbol then sym_valid=0 -> continuous 10'h0FA symbols, sout_valid stays 1; data arriving mid-fill starts right after fill symbol bit 9.
